constraint_verdict_collector: RTL
=================================

// Module: constraint_verdict_collector
// PURPOSE
//  Downstream stage of the per-constraint split_* evaluators. Each cycle, one candidate assignment's
//  NUM_CONS constraint bits (1 = satisfied) arrive on a valid/ready stream. The block registers them
//  and checks whether all constraints are met. It counts satisfying and total candidates per batch.
//  It records the lowest violated constraint index of the batch's first failing candidate, and emits
//  one verdict per batch on a valid/ready output. It feeds the solver's batch scoreboard.
// PARAMETERS
//  NUM_CONS   64                   number of constraint bits per candidate
//  IDX_W      $clog2(NUM_CONS)     width of the constraint index
//  CNT_W      32                   width of the per-batch counters; counters saturate at all-ones
// PORTS
//  clk                 in   1       single clock, rising edge
//  rst_n               in   1       synchronous reset, active-low
//  in_valid            in   1       candidate bits valid
//  in_ready            out  1       block accepts a candidate
//  in_cons             in   NUM_CONS  constraint results; bit i = constraint i satisfied
//  in_last             in   1       candidate is the last of its batch (qualified by in_valid)
//  out_valid           out  1       batch verdict valid
//  out_ready           in   1       consumer accepts the verdict
//  out_total_cnt       out  CNT_W   candidates accepted in the batch
//  out_sat_cnt         out  CNT_W   candidates with all NUM_CONS bits = 1
//  out_all_sat         out  1       out_sat_cnt == out_total_cnt
//  out_fail_idx        out  IDX_W   lowest 0-bit index of the first failing candidate (0 if none)
//  out_fail_vld        out  1       at least one candidate in the batch failed
//  busy                out  1       state != IDLE or pipeline non-empty
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): state=IDLE, pipeline valids=0, all counters and outputs 0;
//    in_ready=0 during reset. Reset mid-batch discards the partial batch; no verdict is emitted.
//  - Accept = in_valid & in_ready. in_ready=1 only in IDLE/ACCUM. in_cons/in_last are
//    don't-care when in_valid=0.
//  - Pipeline: S1 registers in_cons/in_last/valid. S2 computes all_ones and the lowest-zero index
//    (priority encoder) and updates the accumulators. The pipeline never stalls: in_ready gating
//    bounds occupancy.
//  - Accumulators (S2): total += 1; sat += all_ones; both saturate at 2^CNT_W-1.
//    On the first !all_ones of the batch: fail_vld<=1 and fail_idx<=lowest zero. Later failures
//    leave fail_idx unchanged.
//  - FSM:
//      IDLE   -> ACCUM  on accept with in_last=0
//      IDLE   -> DRAIN  on accept with in_last=1 (single-candidate batch)
//      ACCUM  -> DRAIN  on accept with in_last=1
//      DRAIN  -> REPORT when the S2 last-flag is processed (in_ready=0 throughout DRAIN)
//      REPORT -> IDLE   on out_valid & out_ready
//  - Latency: in_last accepted at edge t -> out_valid=1 from t+3. Verdict fields are stable
//    while out_valid=1 & !out_ready.
//  - On leaving REPORT, accumulators clear in the same edge. in_ready=1 on the cycle after the
//    out handshake, never in the same cycle (no input/output overlap).
//  - Batches always hold >=1 candidate; there is no empty-batch verdict.
//  - Simultaneous S2 saturation and new sample: the counter holds at all-ones.
//  - NUM_CONS=1 is legal: IDX_W is forced to 1 and fail_idx is always 0.
// STRUCTURE
//  - constraint_pkg: cvc_state_e {IDLE, ACCUM, DRAIN, REPORT}; default NUM_CONS/CNT_W
//    localparams; verdict struct {total, sat, all_sat, fail_idx, fail_vld}.
//  - Sub-module cons_lowest_zero: combinational NUM_CONS-in -> {found, IDX_W index} priority
//    encoder; instantiated once in S2.
//  - Top level: S1/S2 registers, accumulators, FSM, output register.
// TESTING
//  1. Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, all counters 0,
//     busy=0.
//  2. One-candidate batch: in_cons=all-ones, in_last=1 -> out_valid at +3;
//     total=1, sat=1, all_sat=1, fail_vld=0.
//  3. Batch of 4: cons = all-ones; bit5=0; bits 2 and 9 = 0; all-ones (last) -> total=4, sat=2,
//     all_sat=0, fail_vld=1, fail_idx=5.
//  4. Backpressure: hold out_ready=0 for 10 cycles in REPORT -> verdict stable, in_ready=0;
//     release -> IDLE, in_ready=1 the next cycle.
//  5. Reset mid-batch: 3 candidates accepted, then rst_n=0 for 1 cycle -> no verdict; the next
//     1-candidate batch reports total=1.
//  6. Saturation with CNT_W=4: 20 all-ones candidates -> total=15, sat=15, all_sat=1.

Source files
------------

// File: rtl/constraint_pkg.sv
// Shared types and defaults for the constraint verdict collector and its encoder.
package constraint_pkg;

    localparam int CVC_NUM_CONS = 64;
    localparam int CVC_CNT_W    = 32;

    // A single-bit constraint vector still needs a one-bit index field.
    function automatic int cvc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CVC_IDX_W = cvc_idx_w(CVC_NUM_CONS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } cvc_state_e;

    typedef struct packed {
        logic [CVC_CNT_W-1:0] total;
        logic [CVC_CNT_W-1:0] sat;
        logic                 all_sat;
        logic [CVC_IDX_W-1:0] fail_idx;
        logic                 fail_vld;
    } cvc_verdict_t;

endpackage

// File: rtl/cons_lowest_zero.sv
// Priority encoder: reports whether any constraint bit is 0 and the index of the lowest such bit.
module cons_lowest_zero
    import constraint_pkg::*;
#(
    parameter int NUM_CONS = CVC_NUM_CONS,
    parameter int IDX_W    = cvc_idx_w(NUM_CONS)
) (
    input  logic [NUM_CONS-1:0] i_cons,
    output logic                o_found,
    output logic [IDX_W-1:0]    o_idx
);

    always_comb begin
        o_found = ~(&i_cons);
        o_idx   = '0;
        // Scan downwards so the lowest zero is the last one written.
        for (int i = NUM_CONS - 1; i >= 0; i--) begin
            if (!i_cons[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/constraint_verdict_collector.sv
// Collects per-candidate constraint results into one verdict per batch.
// State | meaning: IDLE no batch open; ACCUM batch open; DRAIN last accepted, pipeline flushing; REPORT verdict offered.
module constraint_verdict_collector
    import constraint_pkg::*;
#(
    parameter int NUM_CONS = CVC_NUM_CONS,
    parameter int CNT_W    = CVC_CNT_W,
    localparam int IDX_W   = cvc_idx_w(NUM_CONS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUM_CONS-1:0] in_cons,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CNT_W-1:0]    out_total_cnt,
    output logic [CNT_W-1:0]    out_sat_cnt,
    output logic                out_all_sat,
    output logic [IDX_W-1:0]    out_fail_idx,
    output logic                out_fail_vld,
    output logic                busy
);

    cvc_state_e          r_state;
    cvc_state_e          w_state_nxt;
    logic                w_accept;
    logic                w_leave_report;
    logic                r_s1_vld;
    logic                r_s1_last;
    logic [NUM_CONS-1:0] r_s1_cons;
    logic                r_s2_last;
    logic                w_found;
    logic [IDX_W-1:0]    w_low_idx;
    logic [CNT_W-1:0]    r_total;
    logic [CNT_W-1:0]    r_sat;
    logic                r_fail_vld;
    logic [IDX_W-1:0]    r_fail_idx;
    logic                r_out_vld;
    logic [CNT_W-1:0]    r_out_total;
    logic [CNT_W-1:0]    r_out_sat;
    logic                r_out_all_sat;
    logic [IDX_W-1:0]    r_out_fail_idx;
    logic                r_out_fail_vld;

    assign in_ready       = rst_n & ((r_state == IDLE) | (r_state == ACCUM));
    assign w_accept       = in_valid & in_ready;
    assign w_leave_report = (r_state == REPORT) & r_out_vld & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = in_last ? DRAIN : ACCUM;
            ACCUM:   if (w_accept && in_last) w_state_nxt = DRAIN;
            DRAIN:   if (r_s2_last) w_state_nxt = REPORT;
            REPORT:  if (w_leave_report) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_cons <= '0;
            r_s2_last <= 1'b0;
        end else begin
            r_s1_vld  <= w_accept;
            r_s1_last <= in_last;
            r_s1_cons <= in_cons;
            r_s2_last <= r_s1_vld & r_s1_last;
        end
    end

    cons_lowest_zero #(
        .NUM_CONS (NUM_CONS),
        .IDX_W    (IDX_W)
    ) u_lowest_zero (
        .i_cons  (r_s1_cons),
        .o_found (w_found),
        .o_idx   (w_low_idx)
    );

    // Accumulators; the pipeline is always empty in REPORT, so clear and update never collide.
    always_ff @(posedge clk) begin
        if (!rst_n || w_leave_report) begin
            r_total    <= '0;
            r_sat      <= '0;
            r_fail_vld <= 1'b0;
            r_fail_idx <= '0;
        end else if (r_s1_vld) begin
            if (!(&r_total)) r_total <= r_total + CNT_W'(1);
            if (!w_found && !(&r_sat)) r_sat <= r_sat + CNT_W'(1);
            if (w_found && !r_fail_vld) begin
                r_fail_vld <= 1'b1;
                r_fail_idx <= w_low_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_vld      <= 1'b0;
            r_out_total    <= '0;
            r_out_sat      <= '0;
            r_out_all_sat  <= 1'b0;
            r_out_fail_idx <= '0;
            r_out_fail_vld <= 1'b0;
        end else if (w_leave_report) begin
            r_out_vld <= 1'b0;
        end else if ((r_state == REPORT) && !r_out_vld) begin
            r_out_vld      <= 1'b1;
            r_out_total    <= r_total;
            r_out_sat      <= r_sat;
            r_out_all_sat  <= (r_sat == r_total);
            r_out_fail_idx <= r_fail_idx;
            r_out_fail_vld <= r_fail_vld;
        end
    end

    assign out_valid     = r_out_vld;
    assign out_total_cnt = r_out_total;
    assign out_sat_cnt   = r_out_sat;
    assign out_all_sat   = r_out_all_sat;
    assign out_fail_idx  = r_out_fail_idx;
    assign out_fail_vld  = r_out_fail_vld;
    assign busy          = (r_state != IDLE) | r_s1_vld | r_s2_last;

endmodule
